// File: rtl/layer_compositor_pkg.sv
// Shared constants and types for the layer compositor.
// Colour defaults, overlay state encoding, counter width helper.
package layer_compositor_pkg;

    localparam int RGB_W = 12;

    localparam logic [RGB_W-1:0] BLACK         = 12'h000;
    localparam logic [RGB_W-1:0] DEF_BG_COLOR  = 12'h69C;
    localparam logic [RGB_W-1:0] DEF_OVL_COLOR = 12'h0F0;
    localparam logic [RGB_W-1:0] DEF_KEY_COLOR = 12'hF0F;

    typedef enum logic [1:0] {
        OVL_NORMAL = 2'd0,
        OVL_FLASH  = 2'd1,
        OVL_SOLID  = 2'd2
    } ovl_state_e;

    // Counter width that stays at least one bit for tiny ranges
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// Pixel-side bundle between the video sources and the compositor.
// master drives layers and timing; slave returns the composed pixel.
interface layer_compositor_if
    import layer_compositor_pkg::*;
#(
    parameter int N_LAYERS = 11
);
    localparam int HW = $clog2(N_LAYERS + 1);

    logic                      bright;
    logic                      v_sync;
    logic [N_LAYERS-1:0]       layer_en;
    logic [RGB_W*N_LAYERS-1:0] layer_rgb;
    logic                      death;
    logic                      game_over;
    logic [RGB_W-1:0]          rgb_out;
    logic [HW-1:0]             hit_layer;

    modport master (
        output bright, v_sync, layer_en, layer_rgb,
        output death, game_over,
        input  rgb_out, hit_layer
    );

    modport slave (
        input  bright, v_sync, layer_en, layer_rgb,
        input  death, game_over,
        output rgb_out, hit_layer
    );

endinterface

// File: rtl/layer_compositor_priority_sel.sv
// Find-first-set over the visible-layer mask.
// Lowest index wins; no visible layer yields the background colour.
module layer_priority_sel
    import layer_compositor_pkg::*;
#(
    parameter int               N_LAYERS = 11,
    parameter logic [RGB_W-1:0] BG_COLOR = DEF_BG_COLOR,
    parameter int               HW       = $clog2(N_LAYERS + 1)
) (
    input  logic [N_LAYERS-1:0]       i_vis,
    input  logic [RGB_W*N_LAYERS-1:0] i_rgb,
    output logic [RGB_W-1:0]          o_rgb,
    output logic [HW-1:0]             o_idx
);

    // Scan from the lowest priority upward so the lowest set index lands last
    always_comb begin
        o_rgb = BG_COLOR;
        o_idx = HW'(N_LAYERS);
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (i_vis[i]) begin
                o_rgb = i_rgb[RGB_W*i +: RGB_W];
                o_idx = HW'(i);
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage VGA layer compositor with colour key and overlay FSM.
// Flash overlay on life lost, latched solid overlay on game over.
module layer_compositor
    import layer_compositor_pkg::*;
#(
    parameter int               N_LAYERS      = 11,
    parameter bit               KEY_EN        = 1'b1,
    parameter logic [RGB_W-1:0] KEY_COLOR     = DEF_KEY_COLOR,
    parameter logic [RGB_W-1:0] BG_COLOR      = DEF_BG_COLOR,
    parameter logic [RGB_W-1:0] OVL_COLOR     = DEF_OVL_COLOR,
    parameter int               FLASH_FRAMES  = 8,
    parameter int               FLASH_TOGGLES = 6
) (
    input logic               clk,
    input logic               reset,
    layer_compositor_if.slave bus
);

    localparam int HW = $clog2(N_LAYERS + 1);
    localparam int FW = cnt_w(FLASH_FRAMES);
    localparam int TW = cnt_w(FLASH_TOGGLES);

    localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);
    localparam logic [TW-1:0] TOG_LAST   = TW'(FLASH_TOGGLES - 1);
    localparam logic [HW-1:0] HIT_NONE   = HW'(N_LAYERS);

    logic                      r_v_sync_q;
    logic                      r_death_q;
    logic                      w_frame_tick;
    logic                      w_death_rise;

    ovl_state_e                r_state;
    ovl_state_e                w_state_nxt;
    logic                      r_phase;
    logic                      w_phase_nxt;
    logic [FW-1:0]             r_frame_cnt;
    logic [FW-1:0]             w_frame_cnt_nxt;
    logic [TW-1:0]             r_tog_cnt;
    logic [TW-1:0]             w_tog_cnt_nxt;

    logic [N_LAYERS-1:0]       w_vis;
    logic [N_LAYERS-1:0]       r_vis;
    logic [RGB_W*N_LAYERS-1:0] r_rgb;
    logic                      r_bright;

    logic [RGB_W-1:0]          w_sel_rgb;
    logic [HW-1:0]             w_sel_idx;
    logic                      w_ovl_on;

    logic [RGB_W-1:0]          r_rgb_out;
    logic [HW-1:0]             r_hit;

    // A key-coloured pixel counts as not drawn
    always_comb begin
        w_vis = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            w_vis[i] = bus.layer_en[i]
                     & ~(KEY_EN & (bus.layer_rgb[RGB_W*i +: RGB_W] == KEY_COLOR));
        end
    end

    // History for the v_sync fall and death rise detectors
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v_sync_q <= 1'b1;
            r_death_q  <= 1'b0;
        end else begin
            r_v_sync_q <= bus.v_sync;
            r_death_q  <= bus.death;
        end
    end

    assign w_frame_tick = r_v_sync_q & ~bus.v_sync;
    assign w_death_rise = bus.death & ~r_death_q;

    // Overlay state and flash counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= OVL_NORMAL;
            r_phase     <= 1'b0;
            r_frame_cnt <= '0;
            r_tog_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_tog_cnt   <= w_tog_cnt_nxt;
        end
    end

    // Game over beats a new death, which beats frame counting
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_frame_cnt_nxt = r_frame_cnt;
        w_tog_cnt_nxt   = r_tog_cnt;
        unique case (r_state)
            OVL_NORMAL, OVL_FLASH: begin
                if (bus.game_over) begin
                    w_state_nxt = OVL_SOLID;
                end else if (w_death_rise) begin
                    w_state_nxt     = OVL_FLASH;
                    w_phase_nxt     = 1'b1;
                    w_frame_cnt_nxt = '0;
                    w_tog_cnt_nxt   = '0;
                end else if (r_state == OVL_FLASH && w_frame_tick) begin
                    if (r_frame_cnt == FRAME_LAST) begin
                        w_frame_cnt_nxt = '0;
                        if (r_tog_cnt == TOG_LAST) begin
                            w_state_nxt   = OVL_NORMAL;
                            w_phase_nxt   = 1'b0;
                            w_tog_cnt_nxt = '0;
                        end else begin
                            w_phase_nxt   = ~r_phase;
                            w_tog_cnt_nxt = r_tog_cnt + 1'b1;
                        end
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Stage 1: capture visibility, colours and blanking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vis    <= '0;
            r_rgb    <= '0;
            r_bright <= 1'b0;
        end else begin
            r_vis    <= w_vis;
            r_rgb    <= bus.layer_rgb;
            r_bright <= bus.bright;
        end
    end

    layer_priority_sel #(
        .N_LAYERS (N_LAYERS),
        .BG_COLOR (BG_COLOR),
        .HW       (HW)
    ) u_sel (
        .i_vis (r_vis),
        .i_rgb (r_rgb),
        .o_rgb (w_sel_rgb),
        .o_idx (w_sel_idx)
    );

    assign w_ovl_on = (r_state == OVL_SOLID)
                    | ((r_state == OVL_FLASH) & r_phase);

    // Stage 2: blanking, then overlay, then the composed pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb_out <= BLACK;
            r_hit     <= HIT_NONE;
        end else if (!r_bright) begin
            r_rgb_out <= BLACK;
            r_hit     <= HIT_NONE;
        end else if (w_ovl_on) begin
            r_rgb_out <= OVL_COLOR;
            r_hit     <= HIT_NONE;
        end else begin
            r_rgb_out <= w_sel_rgb;
            r_hit     <= w_sel_idx;
        end
    end

    assign bus.rgb_out   = r_rgb_out;
    assign bus.hit_layer = r_hit;

endmodule
